// File: rtl/rsa_modmul.sv
// rsa_modmul: interleaved MSB-first shift-add modular multiplier.
// Produces p = (a * b) mod n, one multiplier bit per clock.
module rsa_modmul #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] n,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] p,
  output logic         err
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic [W-1:0]  n_reg;
  logic [W:0]    acc;
  logic [CW-1:0] cnt;
  logic          err_q;
  logic          accept;

  logic [W+1:0]  nx;
  logic [W+1:0]  ax;
  logic [W+1:0]  t_dbl;
  logic [W+1:0]  t_red;
  logic [W+1:0]  t_add;
  logic [W+1:0]  t_out;

  // The done cycle itself is not an acceptance window, so a start
  // overlapping the done pulse never launches a second operation.
  assign accept = (state_q == IDLE) && start && !done;

  assign busy = (state_q != IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = CALC;
        end
      end
      CALC: begin
        if (cnt == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // One interleaved step: double, reduce, conditionally add A, reduce.
  always_comb begin
    nx    = {2'b00, n_reg};
    ax    = {2'b00, a_reg};
    t_dbl = {acc, 1'b0};
    t_red = (t_dbl >= nx) ? (t_dbl - nx) : t_dbl;
    t_add = b_reg[cnt] ? (t_red + ax) : t_red;
    t_out = (t_add >= nx) ? (t_add - nx) : t_add;
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg <= '0;
      b_reg <= '0;
      n_reg <= '0;
      acc   <= '0;
      cnt   <= '0;
      err_q <= 1'b0;
      done  <= 1'b0;
      p     <= '0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            a_reg <= a;
            b_reg <= b;
            n_reg <= n;
            acc   <= '0;
            cnt   <= CW'(W - 1);
            err_q <= (n == '0) || (a >= n);
          end
        end
        CALC: begin
          acc <= t_out[W:0];
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          done <= 1'b1;
          p    <= err_q ? '0 : acc[W-1:0];
          err  <= err_q;
        end
        default: begin
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_modmul.sv
// tb_rsa_modmul: directed and random checks of rsa_modmul.
// Expected results are hand values or a (a*b)%n model.
module tb_rsa_modmul;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] n = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] p;
  logic         err;

  int n_cmp = 0;
  int n_bad = 0;

  rsa_modmul #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .n     (n),
    .busy  (busy),
    .done  (done),
    .p     (p),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Launch one op from just after a rising edge and wait for done.
  task automatic run_op(input string tag,
                        input logic [W-1:0] ia,
                        input logic [W-1:0] ib,
                        input logic [W-1:0] in,
                        input logic [W-1:0] ep,
                        input logic ee);
    int cyc;
    a = ia;
    b = ib;
    n = in;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, ".busy1"}, 32'(busy), 32'd1);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!done && cyc < 40);
    check({tag, ".lat"}, cyc, 17);
    check({tag, ".p"}, 32'(p), 32'(ep));
    check({tag, ".err"}, 32'(err), 32'(ee));
    check({tag, ".busy0"}, 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    check({tag, ".pulse"}, 32'(done), 32'd0);
  endtask

  task automatic count_done(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (done) cnt++;
    end
  endtask

  initial begin
    int cyc;
    int dn;
    int nd;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W-1:0] rn;
    logic [31:0]  prod;

    #1;
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.p", 32'(p), 32'd0);
    check("rst.err", 32'(err), 32'd0);
    #11;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op("basic", 16'h1234, 16'h0005, 16'hFFF1, 16'h5B04, 1'b0);
    run_op("big", 16'hFFEF, 16'hFFEF, 16'hFFF1, 16'h0004, 1'b0);
    run_op("small", 16'h0007, 16'h0009, 16'h000D, 16'h000B, 1'b0);

    run_op("n0", 16'h0003, 16'h0004, 16'h0000, 16'h0000, 1'b1);
    run_op("agen", 16'h0020, 16'h0003, 16'h0010, 16'h0000, 1'b1);
    run_op("clr", 16'h0007, 16'h0009, 16'h000D, 16'h000B, 1'b0);

    run_op("b0", 16'h1234, 16'h0000, 16'hFFF1, 16'h0000, 1'b0);
    run_op("n1", 16'h0000, 16'hBEEF, 16'h0001, 16'h0000, 1'b0);
    run_op("a0", 16'h0000, 16'h0055, 16'h0101, 16'h0000, 1'b0);

    // Starts during CALC and during the done pulse are ignored.
    a = 16'd3;
    b = 16'd5;
    n = 16'h0011;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 0;
    dn = 0;
    do begin
      if (cyc == 4) begin
        a = 16'd9;
        b = 16'd9;
        n = 16'd10;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (done) dn++;
    end while (!done && cyc < 40);
    start = 1'b0;
    check("ign.lat", cyc, 17);
    check("ign.p", 32'(p), 32'h000F);
    a = 16'd2;
    b = 16'd2;
    n = 16'd5;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (done) dn++;
    count_done(25, nd);
    check("ign.ndone", dn + nd, 1);
    check("ign.hold", 32'(p), 32'h000F);
    run_op("ign.next", 16'h0003, 16'h0006, 16'h0011, 16'h0001, 1'b0);

    // Asynchronous reset in the middle of CALC.
    a = 16'h0102;
    b = 16'h0304;
    n = 16'h7001;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mrst.busy", 32'(busy), 32'd0);
    check("mrst.done", 32'(done), 32'd0);
    check("mrst.p", 32'(p), 32'd0);
    check("mrst.err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    count_done(25, nd);
    check("mrst.spur", nd, 0);
    run_op("mrst.op", 16'd2, 16'd3, 16'd7, 16'h0006, 1'b0);

    // Random regression against a (a*b)%n model.
    for (int i = 0; i < 1000; i++) begin
      rn = (i % 50 == 0) ? 16'hFFFF : 16'($urandom_range(1, 65535));
      ra = 16'($urandom % 32'(rn));
      rb = (i % 7 == 0) ? 16'hFFFF : 16'($urandom);
      prod = 32'(ra) * 32'(rb);
      run_op("rnd", ra, rb, rn, 16'(prod % 32'(rn)), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
